// File: rtl/axi4_rd_arbiter.sv
// axi4_rd_arbiter: tenure-based arbiter sharing one AXI4 read port; define AXI4_RD_ARB_FIXED_PRIO_EN for fixed priority (default round-robin)
module axi4_rd_arbiter #(
  parameter int NUM_MST   = 4,
  parameter int AR_WIDTH  = 64,
  parameter int R_WIDTH   = 72,
  parameter int MAX_OUTST = 4
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [NUM_MST-1:0]           m_arvalid,
  input  logic [NUM_MST*AR_WIDTH-1:0]  m_ar,
  output logic [NUM_MST-1:0]           m_arready,
  output logic [NUM_MST-1:0]           m_rvalid,
  output logic [R_WIDTH-1:0]           m_r,
  output logic                         m_rlast,
  input  logic [NUM_MST-1:0]           m_rready,
  output logic                         s_arvalid,
  output logic [AR_WIDTH-1:0]          s_ar,
  input  logic                         s_arready,
  input  logic                         s_rvalid,
  input  logic [R_WIDTH-1:0]           s_r,
  input  logic                         s_rlast,
  output logic                         s_rready,
  output logic [NUM_MST-1:0]           grant
);
  localparam int GW = $clog2(NUM_MST);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAXO = CW'(MAX_OUTST);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_next;
  logic [GW-1:0] gidx, last, win;
  logic [CW-1:0] issued, outst, outst_next;
  logic [NUM_MST-1:0] sel;
  logic busy, ar_open, cur_arvalid, ar_hs, r_done, rel;
  assign busy        = state == BUSY;
  assign sel         = NUM_MST'(1) << gidx;
  assign ar_open     = issued < MAXO;
  assign cur_arvalid = |(m_arvalid & sel);
  assign s_arvalid   = busy & cur_arvalid & ar_open;
  assign s_rready    = busy & |(m_rready & sel);
  assign m_arready   = (busy & s_arready & ar_open) ? sel : '0;
  assign m_rvalid    = (busy & s_rvalid) ? sel : '0;
  assign grant       = busy ? sel : '0;
  assign m_r         = s_r;
  assign m_rlast     = s_rlast;
  assign ar_hs       = s_arvalid & s_arready;
  assign r_done      = s_rvalid & s_rready & s_rlast;
  assign outst_next  = outst + CW'(ar_hs) - CW'(r_done);
  // release only when drained and the master can no longer push an AR
  assign rel         = outst_next == '0 && !ar_hs && (!cur_arvalid || !ar_open);
  always_comb begin
    s_ar = m_ar[AR_WIDTH-1:0];
    for (int i = 0; i < NUM_MST; i++)
      if (gidx == GW'(i)) s_ar = m_ar[i*AR_WIDTH +: AR_WIDTH];
  end
  always_comb begin
    win = '0;
`ifdef AXI4_RD_ARB_FIXED_PRIO_EN
    for (int i = NUM_MST - 1; i >= 0; i--)
      if (m_arvalid[i]) win = GW'(i);
`else
    // lowest requester overall, overridden by the lowest requester above last
    for (int i = NUM_MST - 1; i >= 0; i--)
      if (m_arvalid[i]) win = GW'(i);
    for (int i = NUM_MST - 1; i >= 0; i--)
      if (m_arvalid[i] && GW'(i) > last) win = GW'(i);
`endif
  end
  always_comb state_next = busy ? (rel ? IDLE : BUSY) : (|m_arvalid ? BUSY : IDLE);
  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= IDLE;
      gidx   <= '0;
      last   <= GW'(NUM_MST - 1);
      issued <= '0;
      outst  <= '0;
    end else begin
      state <= state_next;
      if (!busy) begin
        if (|m_arvalid) gidx <= win;
        issued <= '0;
        outst  <= '0;
      end else begin
        issued <= issued + CW'(ar_hs);
        outst  <= outst_next;
        if (rel) last <= gidx;
      end
    end
  end
endmodule
